// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point FFT: load 16 samples, launch datapath, capture, stream results.
// Unload is valid/ready with unbounded stalls; optional FFT16_FRAME_CTRL_BITREV_EN gives natural-order output.
module fft16_frame_ctrl #(
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 16,
   parameter int PIPE_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              fft_start,
   output logic [1023:0]     fft_x,
   input  logic [1023:0]     fft_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data,
   output logic [3:0]        out_index,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [1:0] {LOAD, WAIT, UNLOAD} state_t;

   state_t        state;
   logic [3:0]    load_cnt;
   logic [3:0]    wait_cnt;
   logic [3:0]    out_cnt;
   logic [1023:0] frame_buf;
   logic [1023:0] res_buf;
   logic [31:0]   samp_re;

   // Sign-extend to the 32-bit real lane, then move the integer into Q(32-FRAC_W).FRAC_W.
   assign samp_re = 32'($signed(in_data)) << FRAC_W;

   function automatic logic [3:0] slot_map(input logic [3:0] k);
`ifdef FFT16_FRAME_CTRL_BITREV_EN
      return {k[0], k[1], k[2], k[3]};
`else
      return k;
`endif
   endfunction

   assign fft_x      = frame_buf;
   assign in_ready   = (state == LOAD);
   assign busy       = (state != LOAD);
   assign frame_done = out_valid & out_ready & (out_cnt == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         load_cnt  <= 4'd0;
         wait_cnt  <= 4'd0;
         out_cnt   <= 4'd0;
         fft_start <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 64'd0;
         out_index <= 4'd0;
         frame_buf <= '0;
         res_buf   <= '0;
      end else begin
         fft_start <= 1'b0;
         case (state)
            LOAD: begin
               if (in_valid) begin
                  frame_buf[{load_cnt, 6'd0} +: 64] <= {samp_re, 32'd0};
                  load_cnt <= load_cnt + 4'd1;
                  if (load_cnt == 4'd15) begin
                     state     <= WAIT;
                     fft_start <= 1'b1;
                     wait_cnt  <= 4'd1;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'(PIPE_LAT)) begin
                  // First word comes straight off fft_y since res_buf loads on this same edge.
                  res_buf   <= fft_y;
                  state     <= UNLOAD;
                  out_valid <= 1'b1;
                  out_cnt   <= 4'd0;
                  out_index <= 4'd0;
                  out_data  <= fft_y[{slot_map(4'd0), 6'd0} +: 64];
                  wait_cnt  <= 4'd0;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            UNLOAD: begin
               if (out_ready) begin
                  if (out_cnt == 4'd15) begin
                     state     <= LOAD;
                     out_valid <= 1'b0;
                     out_cnt   <= 4'd0;
                     out_index <= 4'd0;
                     out_data  <= 64'd0;
                  end else begin
                     out_cnt   <= out_cnt + 4'd1;
                     out_index <= out_cnt + 4'd1;
                     out_data  <= res_buf[{slot_map(out_cnt + 4'd1), 6'd0} +: 64];
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Directed bench for fft16_frame_ctrl with a start-triggered identity datapath stub (latency LAT).
module tb_fft16_frame_ctrl;
   localparam int LAT = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_data;
   logic          fft_start;
   logic [1023:0] fft_x;
   logic [1023:0] fft_y;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_data;
   logic [3:0]    out_index;
   logic          busy;
   logic          frame_done;

   int checks = 0;
   int passes = 0;

   fft16_frame_ctrl #(.DATA_W(16), .FRAC_W(16), .PIPE_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .fft_start(fft_start), .fft_x(fft_x), .fft_y(fft_y), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_index(out_index), .busy(busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Stub datapath: fft_y equals fft_x only during WAIT cycle LAT, garbage otherwise.
   int scnt = 0;
   int wc;
   always @(posedge clk) begin
      if (fft_start) scnt <= 1;
      else if (scnt != 0 && scnt < 40) scnt <= scnt + 1;
   end
   always_comb wc = fft_start ? 1 : ((scnt != 0) ? scnt + 1 : 0);
   assign fft_y = (wc == LAT) ? fft_x : {16{64'hDEADBEEF_0BADF00D}};

   logic [3:0]  bitrev_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                    4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
   logic [15:0] samp   [16];
   logic [31:0] exp_re [16];
   logic [63:0] got_d  [16];
   logic [3:0]  got_i  [16];
   logic        got_fd [16];
   int          got_n;
   logic        rdy_seen;

   function automatic int slot_word(input int k);
`ifdef FFT16_FRAME_CTRL_BITREV_EN
      return int'(bitrev_tab[k]);
`else
      return k;
`endif
   endfunction

   task automatic load_samples();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = samp[i];
         @(negedge clk);
      end
   endtask

   task automatic collect(input bit rand_ready, input int budget);
      got_n    = 0;
      rdy_seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         got_d[k] = 'x; got_i[k] = 'x; got_fd[k] = 1'bx;
      end
      for (int c = 0; c < budget && got_n < 16; c++) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (out_valid) rdy_seen = rdy_seen | in_ready;
         if (out_valid && out_ready) begin
            got_d[got_n]  = out_data;
            got_i[got_n]  = out_index;
            got_fd[got_n] = frame_done;
            got_n++;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || fft_start !== 1'b0 || frame_done !== 1'b0)
         $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b fft_start=%b frame_done=%b want 1 0 0 0 0",
                  in_ready, busy, out_valid, fft_start, frame_done);
      else passes++;
      checks++;
      if (out_data !== 64'd0 || out_index !== 4'd0 || fft_x !== 1024'd0)
         $display("FAIL reset_data: out_data=%h out_index=%0d fft_x_nonzero=%b want 0 0 0",
                  out_data, out_index, |fft_x);
      else passes++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [1023:0] ex;
      for (int i = 0; i < 16; i++) begin
         samp[i]   = 16'(i);
         exp_re[i] = 32'(i) * 32'h0001_0000;
      end
      for (int w = 0; w < 16; w++) ex[64*w +: 64] = {exp_re[w], 32'h0};
      load_samples();
      in_valid = 1'b0;
      checks++;
      if (fft_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL b2b_start: fft_start=%b in_ready=%b busy=%b want 1 0 1", fft_start, in_ready, busy);
      else passes++;
      checks++;
      if (fft_x !== ex)
         $display("FAIL b2b_fft_x: word15=%h word1=%h want %h %h",
                  fft_x[64*15 +: 64], fft_x[64 +: 64], ex[64*15 +: 64], ex[64 +: 64]);
      else passes++;
      collect(1'b0, 100);
      checks++;
      if (got_n !== 16) $display("FAIL b2b_count: handshakes=%0d want 16", got_n);
      else passes++;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_d[k] !== {exp_re[slot_word(k)], 32'h0} || got_i[k] !== 4'(k) || got_fd[k] !== (k == 15))
            $display("FAIL b2b_out k=%0d: data=%h idx=%0d fd=%b want data=%h idx=%0d fd=%b",
                     k, got_d[k], got_i[k], got_fd[k], {exp_re[slot_word(k)], 32'h0}, k, (k == 15));
         else passes++;
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL b2b_end: out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
      else passes++;
   endtask

   task automatic test_negative();
      for (int i = 0; i < 16; i++) begin
         samp[i]   = 16'(i);
         exp_re[i] = 32'(i) * 32'h0001_0000;
      end
      samp[0] = 16'hFFFF; exp_re[0] = 32'hFFFF_0000;
      samp[1] = 16'h8000; exp_re[1] = 32'h8000_0000;
      samp[2] = 16'h7FFF; exp_re[2] = 32'h7FFF_0000;
      load_samples();
      in_valid = 1'b0;
      collect(1'b0, 100);
      checks++;
      if (got_n !== 16) $display("FAIL neg_count: handshakes=%0d want 16", got_n);
      else passes++;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_d[k] !== {exp_re[slot_word(k)], 32'h0} || got_i[k] !== 4'(k))
            $display("FAIL neg_out k=%0d: data=%h idx=%0d want data=%h idx=%0d",
                     k, got_d[k], got_i[k], {exp_re[slot_word(k)], 32'h0}, k);
         else passes++;
      end
   endtask

   task automatic test_pipe_lat();
      for (int i = 0; i < 16; i++) begin
         samp[i]   = 16'(i + 100);
         exp_re[i] = 32'(i + 100) * 32'h0001_0000;
      end
      load_samples();
      in_data = 16'h5555;
      for (int j = 1; j <= LAT; j++) begin
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0 || fft_start !== (j == 1))
            $display("FAIL lat_wait cyc=%0d: in_ready=%b busy=%b out_valid=%b fft_start=%b want 0 1 0 %b",
                     j, in_ready, busy, out_valid, fft_start, (j == 1));
         else passes++;
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1 || out_index !== 4'd0 || out_data !== {exp_re[slot_word(0)], 32'h0})
         $display("FAIL lat_capture: out_valid=%b idx=%0d data=%h want 1 0 %h",
                  out_valid, out_index, out_data, {exp_re[slot_word(0)], 32'h0});
      else passes++;
      collect(1'b0, 100);
      in_valid = 1'b0;
      checks++;
      if (rdy_seen !== 1'b0) $display("FAIL lat_unload_ready: in_ready_seen=%b want 0", rdy_seen);
      else passes++;
      checks++;
      if (got_n !== 16) $display("FAIL lat_count: handshakes=%0d want 16", got_n);
      else passes++;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_d[k] !== {exp_re[slot_word(k)], 32'h0} || got_i[k] !== 4'(k))
            $display("FAIL lat_out k=%0d: data=%h idx=%0d want data=%h idx=%0d",
                     k, got_d[k], got_i[k], {exp_re[slot_word(k)], 32'h0}, k);
         else passes++;
      end
   endtask

   task automatic test_stall();
      int n = 0;
      int stall = 0;
      int fdc = 0;
      for (int i = 0; i < 16; i++) begin
         samp[i]   = 16'(7 * i + 1);
         exp_re[i] = 32'(7 * i + 1) * 32'h0001_0000;
      end
      load_samples();
      in_valid = 1'b0;
      for (int c = 0; c < 400 && n < 16; c++) begin
         if (out_valid) begin
            checks++;
            if (out_index !== 4'(n) || out_data !== {exp_re[slot_word(n)], 32'h0})
               $display("FAIL stall_hold n=%0d: idx=%0d data=%h want idx=%0d data=%h",
                        n, out_index, out_data, n, {exp_re[slot_word(n)], 32'h0});
            else passes++;
         end
         if (out_valid && n == 7 && stall < 10) begin
            out_ready = 1'b0;
            stall++;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         #1;
         if (frame_done) begin
            fdc++;
            checks++;
            if (!(out_valid && out_ready && n == 15))
               $display("FAIL stall_done: frame_done at n=%0d valid=%b ready=%b want n=15 with handshake",
                        n, out_valid, out_ready);
            else passes++;
         end
         if (out_valid && out_ready) n++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if (n !== 16 || stall !== 10 || fdc !== 1 || out_valid !== 1'b0)
         $display("FAIL stall_summary: handshakes=%0d stalls=%0d done_pulses=%0d out_valid=%b want 16 10 1 0",
                  n, stall, fdc, out_valid);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int extra = 0;
      for (int i = 0; i < 16; i++) begin
         samp[i]   = 16'(15 - i);
         exp_re[i] = 32'(15 - i) * 32'h0001_0000;
      end
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = samp[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || fft_x !== 1024'd0)
         $display("FAIL rstload: in_ready=%b busy=%b out_valid=%b fft_x_nonzero=%b want 1 0 0 0",
                  in_ready, busy, out_valid, |fft_x);
      else passes++;
      load_samples();
      in_valid = 1'b0;
      for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) $display("FAIL rstunl_reach: out_valid=%b want 1", out_valid);
      else passes++;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_index !== 4'd3) $display("FAIL rstunl_k: out_index=%0d want 3", out_index);
      else passes++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'd0 || out_index !== 4'd0)
         $display("FAIL rstunl: in_ready=%b busy=%b out_valid=%b data=%h idx=%0d want 1 0 0 0 0",
                  in_ready, busy, out_valid, out_data, out_index);
      else passes++;
      load_samples();
      in_valid = 1'b0;
      collect(1'b0, 100);
      checks++;
      if (got_n !== 16) $display("FAIL rst_frame_count: handshakes=%0d want 16", got_n);
      else passes++;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_d[k] !== {exp_re[slot_word(k)], 32'h0} || got_i[k] !== 4'(k))
            $display("FAIL rst_frame_out k=%0d: data=%h idx=%0d want data=%h idx=%0d",
                     k, got_d[k], got_i[k], {exp_re[slot_word(k)], 32'h0}, k);
         else passes++;
      end
      for (int c = 0; c < 6; c++) begin
         if (out_valid) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra !== 0) $display("FAIL rst_leftover: extra_valid_cycles=%0d want 0", extra);
      else passes++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'd0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_back_to_back();
      test_negative();
      test_pipe_lat();
      test_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
